// File: rtl/rca4_seq_ctrl.sv
// Two-requester 16-bit adder sequencer: time-shares one external 4-bit ripple-carry adder
// over four nibble steps. Define RCA_SEQ_OVF_EN to add the rsp_ovf signed-overflow output.
module rca4_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_ci,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_co,
`ifdef RCA_SEQ_OVF_EN
  output logic        rsp_ovf,
`endif
  output logic [3:0]  add_a,
  output logic [3:0]  add_b,
  output logic        add_ci,
  input  logic [3:0]  add_s,
  input  logic        add_co
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        ptr_q, ptr_d;
  logic [15:0] a_q, b_q, sum_q;
  logic        ci_q, id_q, carry_q;
  logic        grant_id;
  logic        accept;
`ifdef RCA_SEQ_OVF_EN
  logic        ovf_q;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ptr_q;
      default: grant_id = 1'b0;
    endcase
  end

  assign accept    = !rst && (state_q == StIdle) && (req_valid != 2'b00);
  assign req_ready = accept ? (2'b01 << grant_id) : 2'b00;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ptr_d   = ptr_q;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_ci  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          k_d     = 2'd0;
          ptr_d   = ~grant_id;
        end
      end
      StRun: begin
        add_a  = a_q[{k_q, 2'b00} +: 4];
        add_b  = b_q[{k_q, 2'b00} +: 4];
        add_ci = (k_q == 2'd0) ? ci_q : carry_q;
        if (k_q == 2'd3) begin
          state_d = StDone;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Outputs read as zero for the whole reset cycle, not just after the edge.
    if (rst) begin
      add_a  = 4'h0;
      add_b  = 4'h0;
      add_ci = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= 16'h0;
      b_q     <= 16'h0;
      ci_q    <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= 16'h0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= grant_id ? req_a[31:16] : req_a[15:0];
        b_q  <= grant_id ? req_b[31:16] : req_b[15:0];
        ci_q <= req_ci[grant_id];
        id_q <= grant_id;
      end
      if (state_q == StRun) begin
        sum_q[{k_q, 2'b00} +: 4] <= add_s;
        carry_q                  <= add_co;
      end
    end
  end

`ifdef RCA_SEQ_OVF_EN
  // Overflow uses the top result nibble straight from the adder in the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && k_q == 2'd3) begin
      ovf_q <= (a_q[15] == b_q[15]) && (add_s[3] != a_q[15]);
    end
  end

  assign rsp_ovf = rsp_valid & ovf_q;
`endif

  assign rsp_valid = !rst && (state_q == StDone);
  assign rsp_sum   = rsp_valid ? sum_q : 16'h0;
  assign rsp_co    = rsp_valid & carry_q;
  assign rsp_id    = rsp_valid & id_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_sum) && $stable(rsp_id) &&
                                   $stable(rsp_co)));

endmodule

// File: tb/tb_rca4_seq_ctrl.sv
// Self-checking bench for rca4_seq_ctrl: directed vector table, multi-cycle corner sequences
// and randomized traffic against an arithmetic/round-robin reference model.
module tb_rca4_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_ci;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_co;
  logic [15:0] rsp_sum;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_ci, add_co;
`ifdef RCA_SEQ_OVF_EN
  logic        rsp_ovf;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic model_ptr;

  logic [15:0] got_sum;
  logic        got_co, got_id, got_ovf;

  typedef struct {
    logic [1:0]  mask;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        id;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the shared external 4-bit adder.
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

  rca4_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ci    (req_ci),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co),
`ifdef RCA_SEQ_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction from request to response retirement; hold = DONE cycles with rsp_ready low.
  task automatic run_txn(input logic [1:0] mask, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a1, input logic [15:0] b1, input logic [1:0] ci,
                         input int hold, input string tag,
                         output logic [15:0] sum, output logic co, output logic id,
                         output logic ovf);
    int          n, t_acc, g;
    logic [15:0] a, b;
    logic        c;
    int unsigned m, cin;
    g = (mask == 2'b11) ? (model_ptr ? 1 : 0) : (mask[1] ? 1 : 0);
    a = (g == 1) ? a1 : a0;
    b = (g == 1) ? b1 : b0;
    c = ci[g];
    req_valid = mask;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_ci    = ci;
    rsp_ready = (hold == 0);
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(2'b01 << g));
    model_ptr = (g == 0);
    t_acc = cyc;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_valid = 2'b00;
      #1;
      m   = (32'd1 << (4 * k)) - 32'd1;
      cin = (k == 0) ? 32'(c) :
            ((((32'(a) & m) + (32'(b) & m) + 32'(c)) >> (4 * k)) & 32'd1);
      check({tag, "_add_a"}, 32'(add_a), (32'(a) >> (4 * k)) & 32'hF);
      check({tag, "_add_b"}, 32'(add_b), (32'(b) >> (4 * k)) & 32'hF);
      check({tag, "_add_ci"}, 32'(add_ci), cin);
      check({tag, "_run_idle"}, {30'b0, rsp_valid, |req_ready}, 32'd0);
    end
    @(posedge clk); #2;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_latency"}, 32'(cyc - t_acc), 32'd5);
    sum = rsp_sum;
    co  = rsp_co;
    id  = rsp_id;
`ifdef RCA_SEQ_OVF_EN
    ovf = rsp_ovf;
`else
    ovf = 1'b0;
`endif
    check({tag, "_id"}, 32'(rsp_id), 32'(g));
    if (hold > 0) begin
      for (int h = 1; h < hold; h++) begin
        @(posedge clk); #1;
        req_valid = 2'b11;
        #1;
        check({tag, "_hold"}, {13'b0, rsp_valid, rsp_id, rsp_co, rsp_sum},
              {13'b0, 1'b1, id, co, sum});
        check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      #1;
      check({tag, "_release"}, 32'(rsp_valid), 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_one_rsp"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_n;
    int          acc_cyc[4];
    int          acc_g[4];
    int          rv_cnt;
    logic        exp_g;
    logic [1:0]  mask;
    logic [15:0] ra0, rb0, ra1, rb1, ea, eb;
    logic [1:0]  rci;
    logic [16:0] full;

    vecs[0] = '{2'b01, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{2'b01, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b01, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2'b10, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};

    // Reset: all outputs low even with both requesters asking.
    rst       = 1'b1;
    req_valid = 2'b11;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'hFFFF_FFFF;
    req_ci    = 2'b11;
    rsp_ready = 1'b1;
    model_ptr = 1'b0;
    #1;
    check("reset_t0_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp", {13'b0, rsp_valid, rsp_id, rsp_co, rsp_sum}, 32'd0);
    check("reset_adder", {23'b0, add_a, add_b, add_ci}, 32'd0);
`ifdef RCA_SEQ_OVF_EN
    check("reset_ovf", 32'(rsp_ovf), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention: both valid continuously, grants must alternate six cycles apart.
    req_a  = {16'h1111, 16'h2222};
    req_b  = {16'h0101, 16'h0202};
    req_ci = 2'b00;
    acc_n  = 0;
    for (int i = 0; i < 40 && acc_n < 4; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        acc_cyc[acc_n] = cyc;
        acc_g[acc_n]   = req_ready[1] ? 1 : 0;
        acc_n++;
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    check("contention_accepts", 32'(acc_n), 32'd4);
    for (int i = 0; i < acc_n; i++) begin
      check("contention_grant", 32'(acc_g[i]), 32'(model_ptr));
      model_ptr = ~model_ptr;
      if (i > 0) check("contention_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);
    end
    repeat (8) @(posedge clk);
    #1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      ra0 = 16'($urandom);
      rb0 = 16'($urandom);
      ra1 = 16'($urandom);
      rb1 = 16'($urandom);
      if (vecs[i].mask[1]) begin
        ra1 = vecs[i].a;
        rb1 = vecs[i].b;
      end else begin
        ra0 = vecs[i].a;
        rb0 = vecs[i].b;
      end
      run_txn(vecs[i].mask, ra0, rb0, ra1, rb1, {vecs[i].ci, vecs[i].ci}, 0, "vec",
              got_sum, got_co, got_id, got_ovf);
      check("vec_sum", 32'(got_sum), 32'(vecs[i].sum));
      check("vec_co", 32'(got_co), 32'(vecs[i].co));
      check("vec_id", 32'(got_id), 32'(vecs[i].id));
`ifdef RCA_SEQ_OVF_EN
      check("vec_ovf", 32'(got_ovf), 32'(vecs[i].ovf));
`endif
    end

    // Backpressure: ten DONE cycles with rsp_ready low.
    run_txn(2'b01, 16'hABCD, 16'h1357, 16'h0, 16'h0, 2'b01, 10, "bp",
            got_sum, got_co, got_id, got_ovf);
    check("bp_sum", {15'b0, got_co, got_sum}, 32'(17'h0ABCD + 17'h01357 + 17'h1));

    // Reset in RUN step 2: no response, pointer back to 0.
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'hFFFF};
    req_b     = {16'h0000, 16'hFFFF};
    req_ci    = 2'b00;
    #1;
    check("midrst_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_adder", {23'b0, add_a, add_b, add_ci}, 32'd0);
    check("midrst_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_ptr = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rsp_valid) rv_cnt++;
      @(posedge clk); #1;
    end
    check("midrst_no_rsp", 32'(rv_cnt), 32'd0);
    run_txn(2'b11, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 2'b00, 0, "postrst",
            got_sum, got_co, got_id, got_ovf);
    check("postrst_id", 32'(got_id), 32'd0);
    check("postrst_sum", 32'(got_sum), 32'h7);

    // Randomized traffic against the arithmetic and round-robin model.
    for (int i = 0; i < 40; i++) begin
      mask  = 2'($urandom_range(1, 3));
      ra0   = 16'($urandom);
      rb0   = 16'($urandom);
      ra1   = 16'($urandom);
      rb1   = 16'($urandom);
      rci   = 2'($urandom);
      exp_g = (mask == 2'b11) ? model_ptr : mask[1];
      ea    = exp_g ? ra1 : ra0;
      eb    = exp_g ? rb1 : rb0;
      full  = {1'b0, ea} + {1'b0, eb} + {16'b0, rci[exp_g]};
      run_txn(mask, ra0, rb0, ra1, rb1, rci, int'($urandom_range(0, 2)), "rnd",
              got_sum, got_co, got_id, got_ovf);
      check("rnd_sum", {15'b0, got_co, got_sum}, {15'b0, full});
      check("rnd_id", 32'(got_id), 32'(exp_g));
`ifdef RCA_SEQ_OVF_EN
      check("rnd_ovf", 32'(got_ovf), 32'((ea[15] == eb[15]) && (full[15] != ea[15])));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
